// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-read-port register file.
package reg_file_pkg;

   // Widest data path the merge helper supports; callers cast in and out.
   localparam int MERGE_W = 64;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_CLR  = 1'b1
   } clr_state_e;

   function automatic logic [MERGE_W-1:0] mask_merge(
      input logic [MERGE_W-1:0] old_val,
      input logic [MERGE_W-1:0] new_val,
      input logic [MERGE_W-1:0] mask
   );
      return (old_val & ~mask) | (new_val & mask);
   endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One read port: register-0 zeroing, write bypass and optional output register.
module reg_file_rd_port #(
   parameter int DW      = 8,
   parameter int PW      = 4,
   parameter int RD_LAT  = 0,
   parameter int BYPASS  = 1,
   parameter int R0_ZERO = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [PW-1:0] rd_addr,
   input  logic [DW-1:0] entry_val,
   input  logic          wr_en,
   input  logic [PW-1:0] wr_addr,
   input  logic [DW-1:0] wr_merge,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] rd_val;
   logic [DW-1:0] rd_q, rd_d;

   always_comb begin
      rd_val = entry_val;
      if ((R0_ZERO != 0) && (rd_addr == '0)) begin
         rd_val = '0;
      end else if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr)) begin
         rd_val = wr_merge;
      end
      rd_d = rd_val;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q <= '0;
      end else begin
         rd_q <= rd_d;
      end
   end

   assign rd_data = (RD_LAT != 0) ? rd_q : rd_val;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-read-port register file with masked writes and a
// background clear sweep.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no sweep; clr_req starts one with ptr = 0
//   ST_CLR  | zeroing entry[ptr] each cycle, ptr counts up to all-ones
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int DW      = 8,
   parameter int PW      = 4,
   parameter int NR      = 2,
   parameter int RD_LAT  = 0,
   parameter int BYPASS  = 1,
   parameter int R0_ZERO = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NR*PW-1:0] rd_addr,
   output logic [NR*DW-1:0] rd_data,
   input  logic             wr_en,
   input  logic [PW-1:0]    wr_addr,
   input  logic [DW-1:0]    wr_data,
   input  logic [DW-1:0]    wr_mask,
   input  logic             clr_req,
   output logic             clr_busy,
   output logic             clr_done
);

   localparam int DEPTH = 2 ** PW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   clr_state_e    state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic          done_q, done_d;
   logic [DW-1:0] wr_merge;
   logic          wr_keep;

   assign wr_merge = DW'(mask_merge(MERGE_W'(mem_q[wr_addr]),
                                    MERGE_W'(wr_data),
                                    MERGE_W'(wr_mask)));
   assign wr_keep  = wr_en && !((R0_ZERO != 0) && (wr_addr == '0));

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clr_req) begin
               state_d = ST_CLR;
               ptr_d   = '0;
            end
         end
         ST_CLR: begin
            ptr_d = ptr_q + PW'(1);
            if (ptr_q == {PW{1'b1}}) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The external write is applied after the sweep so it wins on a ptr match.
   always_comb begin
      mem_d = mem_q;
      if (state_q == ST_CLR) begin
         mem_d[ptr_q] = '0;
      end
      if (wr_keep) begin
         mem_d[wr_addr] = wr_merge;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q   <= '{default: '0};
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         state_q <= state_d;
         ptr_q   <= ptr_d;
         done_q  <= done_d;
      end
   end

   assign clr_busy = (state_q == ST_CLR);
   assign clr_done = done_q;

   for (genvar g = 0; g < NR; g++) begin : g_rd
      reg_file_rd_port #(
         .DW     (DW),
         .PW     (PW),
         .RD_LAT (RD_LAT),
         .BYPASS (BYPASS),
         .R0_ZERO(R0_ZERO)
      ) u_rd (
         .clk      (clk),
         .reset    (reset),
         .rd_addr  (rd_addr[g*PW +: PW]),
         .entry_val(mem_q[rd_addr[g*PW +: PW]]),
         .wr_en    (wr_en),
         .wr_addr  (wr_addr),
         .wr_merge (wr_merge),
         .rd_data  (rd_data[g*DW +: DW])
      );
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: three configurations driven in lockstep against a
// behavioural model, a vector table and hand-built sweep/reset sequences.
module tb_reg_file_mp;

   logic clk = 1'b0;
   initial forever #5 clk = ~clk;

   logic        reset, wr_en, clr_req;
   logic [3:0]  wr_addr;
   logic [7:0]  wr_data, wr_mask;
   logic [7:0]  rd_addr;
   logic [15:0] rd_data_a, rd_data_b, rd_data_c;
   logic        busy_a, done_a, busy_b, done_b, busy_c, done_c;

   // A: combinational + bypass. B: registered, no bypass, r0 hardwired. C: combinational, no bypass.
   reg_file_mp #(.DW(8), .PW(4), .NR(2), .RD_LAT(0), .BYPASS(1), .R0_ZERO(0)) u_dut_a (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
      .clr_req(clr_req), .clr_busy(busy_a), .clr_done(done_a));
   reg_file_mp #(.DW(8), .PW(4), .NR(2), .RD_LAT(1), .BYPASS(0), .R0_ZERO(1)) u_dut_b (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
      .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b));
   reg_file_mp #(.DW(8), .PW(4), .NR(2), .RD_LAT(0), .BYPASS(0), .R0_ZERO(0)) u_dut_c (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_c),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
      .clr_req(clr_req), .clr_busy(busy_c), .clr_done(done_c));

   int n_tests = 0;
   int n_fail  = 0;
   int busy_cnt = 0;
   int done_cnt = 0;

   logic [7:0]  mem_a [16];
   logic [7:0]  mem_b [16];
   logic        busy_m, done_m;
   logic [3:0]  ptr_m;
   logic [15:0] sb_q [$];

   typedef struct {
      logic       we;
      logic [3:0] wa;
      logic [7:0] wd;
      logic [7:0] wm;
      logic [3:0] ra0;
      logic [3:0] ra1;
      logic [7:0] ea0;
      logic [7:0] ea1;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] merge(input logic [7:0] o, input logic [7:0] d, input logic [7:0] m);
      return (o & ~m) | (d & m);
   endfunction

   // which: 0 = A (bypass), 1 = B (r0 zero, no bypass), 2 = C (no bypass)
   function automatic logic [7:0] rdval(input int which, input logic [3:0] a);
      logic [7:0] v;
      v = (which == 1) ? mem_b[a] : mem_a[a];
      if ((which == 1) && (a == 4'd0)) v = 8'h00;
      else if ((which == 0) && wr_en && (wr_addr == a)) v = merge(mem_a[a], wr_data, wr_mask);
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         mem_a[i] = 8'h00;
         mem_b[i] = 8'h00;
      end
      busy_m = 1'b0;
      done_m = 1'b0;
      ptr_m  = 4'd0;
   endtask

   task automatic model_update();
      logic [7:0] na, nb;
      if (reset) begin
         model_reset();
      end else begin
         na = merge(mem_a[wr_addr], wr_data, wr_mask);
         nb = merge(mem_b[wr_addr], wr_data, wr_mask);
         done_m = busy_m && (ptr_m == 4'hF);
         if (busy_m) begin
            mem_a[ptr_m] = 8'h00;
            mem_b[ptr_m] = 8'h00;
            if (ptr_m == 4'hF) busy_m = 1'b0;
            ptr_m = ptr_m + 4'd1;
         end else if (clr_req) begin
            busy_m = 1'b1;
            ptr_m  = 4'd0;
         end
         if (wr_en) begin
            mem_a[wr_addr] = na;
            if (wr_addr != 4'd0) mem_b[wr_addr] = nb;
         end
      end
   endtask

   task automatic drive(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                        input logic [7:0] wm, input logic [3:0] r0, input logic [3:0] r1,
                        input logic cr);
      wr_en   = we;
      wr_addr = wa;
      wr_data = wd;
      wr_mask = wm;
      rd_addr = {r1, r0};
      clr_req = cr;
   endtask

   // One clock: check everything at the negedge, push B's expectation, advance the model.
   task automatic step();
      logic [3:0]  a;
      logic [15:0] exp_b;
      @(negedge clk);
      if (busy_a) busy_cnt++;
      if (done_a) done_cnt++;
      for (int p = 0; p < 2; p++) begin
         a = rd_addr[p*4 +: 4];
         chk("rd_a", 16'(rd_data_a[p*8 +: 8]), 16'(rdval(0, a)));
         chk("rd_c", 16'(rd_data_c[p*8 +: 8]), 16'(rdval(2, a)));
      end
      if (sb_q.size() != 0) begin
         exp_b = sb_q.pop_front();
         chk("rd_b", rd_data_b, exp_b);
      end else begin
         n_tests++;
         n_fail++;
         $display("FAIL sb_empty: got no entry expected one");
      end
      if (reset) sb_q.push_back(16'h0000);
      else sb_q.push_back({rdval(1, rd_addr[7:4]), rdval(1, rd_addr[3:0])});
      chk("busy_a", 16'(busy_a), 16'(busy_m));
      chk("done_a", 16'(done_a), 16'(done_m));
      chk("busy_b", 16'(busy_b), 16'(busy_m));
      chk("done_b", 16'(done_b), 16'(done_m));
      chk("busy_c", 16'(busy_c), 16'(busy_m));
      chk("done_c", 16'(done_c), 16'(done_m));
      @(posedge clk);
      model_update();
      #1;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 4'd3, 8'hA5, 8'hFF, 4'd3, 4'd4, 8'hA5, 8'h00};
      vecs[1]  = '{1'b0, 4'd0, 8'h00, 8'h00, 4'd3, 4'd3, 8'hA5, 8'hA5};
      vecs[2]  = '{1'b1, 4'd3, 8'h0F, 8'h0F, 4'd3, 4'd0, 8'hAF, 8'h00};
      vecs[3]  = '{1'b1, 4'd3, 8'h00, 8'h00, 4'd3, 4'd3, 8'hAF, 8'hAF};
      vecs[4]  = '{1'b0, 4'd0, 8'h00, 8'h00, 4'd3, 4'd5, 8'hAF, 8'h00};
      vecs[5]  = '{1'b1, 4'd5, 8'h3C, 8'hFF, 4'd3, 4'd5, 8'hAF, 8'h3C};
      vecs[6]  = '{1'b0, 4'd0, 8'h00, 8'h00, 4'd5, 4'd3, 8'h3C, 8'hAF};
      vecs[7]  = '{1'b1, 4'd1, 8'h5A, 8'hF0, 4'd1, 4'd2, 8'h50, 8'h00};
      vecs[8]  = '{1'b1, 4'd0, 8'hFF, 8'hFF, 4'd0, 4'd1, 8'hFF, 8'h50};
      vecs[9]  = '{1'b0, 4'd0, 8'h00, 8'h00, 4'd0, 4'd0, 8'hFF, 8'hFF};
      vecs[10] = '{1'b1, 4'd7, 8'hFF, 8'h3C, 4'd7, 4'd6, 8'h3C, 8'h00};
      vecs[11] = '{1'b1, 4'd7, 8'h00, 8'h0C, 4'd7, 4'd1, 8'h30, 8'h50};
      vecs[12] = '{1'b0, 4'd0, 8'h00, 8'h00, 4'd7, 4'd5, 8'h30, 8'h3C};

      reset = 1'b1;
      drive(1'b0, 4'd0, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      sb_q.push_back(16'h0000);

      // Writes, masks, bypass and r0 handling from the vector table.
      for (int v = 0; v < 13; v++) begin
         drive(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].wm, vecs[v].ra0, vecs[v].ra1, 1'b0);
         #1;
         chk("vec_p0", 16'(rd_data_a[7:0]),  16'(vecs[v].ea0));
         chk("vec_p1", 16'(rd_data_a[15:8]), 16'(vecs[v].ea1));
         step();
      end

      // Fill, then sweep with writes around the pointer and a redundant clr_req.
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, i[3:0], 8'h11, 8'hFF, i[3:0], 4'd0, 1'b0);
         step();
      end
      busy_cnt = 0;
      done_cnt = 0;
      drive(1'b0, 4'd0, 8'h00, 8'h00, 4'd0, 4'd1, 1'b1);
      step();
      for (int k = 0; k < 16; k++) begin
         drive((k == 4) || (k == 8) || (k == 10),
               (k == 4) ? 4'd15 : ((k == 8) ? 4'd2 : 4'd10),
               (k == 10) ? 8'h5A : 8'h77, 8'hFF, k[3:0], 4'd15, (k == 6));
         step();
      end
      drive(1'b0, 4'd0, 8'h00, 8'h00, 4'd2, 4'd15, 1'b0);
      #1;
      chk("done_pulse", 16'(done_a), 16'd1);
      chk("sweep_r2",   16'(rd_data_a[7:0]),  16'h0077);
      chk("sweep_r15",  16'(rd_data_a[15:8]), 16'h0000);
      step();
      chk("busy_cycles", 16'(busy_cnt), 16'd16);
      chk("done_count",  16'(done_cnt), 16'd1);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 4'd0, 8'h00, 8'h00, 4'(2*i), 4'(2*i+1), 1'b0);
         #1;
         chk("after_sweep_p0", 16'(rd_data_a[7:0]),
             (2*i == 2) ? 16'h0077 : ((2*i == 10) ? 16'h005A : 16'h0000));
         chk("after_sweep_p1", 16'(rd_data_a[15:8]), 16'h0000);
         step();
      end

      // Second sweep; clr_req in its done cycle starts a third, which reset aborts.
      drive(1'b0, 4'd0, 8'h00, 8'h00, 4'd0, 4'd0, 1'b1);
      step();
      for (int k = 0; k < 16; k++) begin
         drive(1'b0, 4'd0, 8'h00, 8'h00, k[3:0], 4'd2, 1'b0);
         step();
      end
      drive(1'b0, 4'd0, 8'h00, 8'h00, 4'd0, 4'd0, 1'b1);
      step();
      chk("req_in_done", 16'(busy_a), 16'd1);
      done_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         if (k == 7) begin
            reset = 1'b1;
            drive(1'b1, 4'd9, 8'hEE, 8'hFF, 4'd9, 4'd12, 1'b0);
         end else begin
            drive((k == 3), 4'd12, 8'h44, 8'hFF, 4'd12, 4'd9, 1'b0);
         end
         step();
      end
      reset = 1'b0;
      chk("rst_busy", 16'(busy_a), 16'd0);
      chk("rst_done", 16'(done_a), 16'd0);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 4'd0, 8'h00, 8'h00, 4'(2*i), 4'(2*i+1), 1'b0);
         #1;
         chk("after_rst_p0", 16'(rd_data_a[7:0]),  16'h0000);
         chk("after_rst_p1", 16'(rd_data_a[15:8]), 16'h0000);
         step();
      end
      chk("no_done_after_rst", 16'(done_cnt), 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
